// File: rtl/mul_seg_approx_seq_if.sv
// mul_seg_approx_seq_if
// Request/response bundle for the segmented approximate multiplier.
//   in_valid/in_ready : operand handshake (a, b, level)
//   out_valid/out_ready : result handshake (o)
// master drives requests and accepts results; slave is the multiplier.
interface mul_seg_approx_seq_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
);
    localparam int unsigned N  = WIDTH / SEG;
    localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [LW-1:0]        level;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   o;

    modport master (
        output in_valid, a, b, level, out_ready,
        input  in_ready, out_valid, o
    );

    modport slave (
        input  in_valid, a, b, level, out_ready,
        output in_ready, out_valid, o
    );
endinterface

// File: rtl/mul_seg_approx_seq.sv
// mul_seg_approx_seq
// Sequential segmented approximate unsigned multiplier. Operands are split into
// SEG-bit segments; only the top (L+1)x(L+1) segment products are accumulated,
// one SEG x SEG product per cycle. L = N-1 gives the exact product.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   io_bus : slave side of mul_seg_approx_seq_if (operands, level, result)
module mul_seg_approx_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mul_seg_approx_seq_if.slave   io_bus
);
    localparam int unsigned N   = WIDTH / SEG;
    localparam int unsigned LW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SHW = $clog2(2 * WIDTH);
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [LW-1:0]        r_first;   // lowest segment index in use, N-1-L
    logic [LW-1:0]        r_i;
    logic [LW-1:0]        r_j;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_o;
    logic                 r_in_ready;
    logic                 r_out_valid;

    logic [LW-1:0]        w_level;
    logic [LW-1:0]        w_first;
    logic [SEG-1:0]       w_ai;
    logic [SEG-1:0]       w_bj;
    logic [2*SEG-1:0]     w_prod;
    logic [SHW-1:0]       w_shamt;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_sum;

    always_comb begin
        // Levels beyond N-1 (possible when N is not a power of two) clamp to exact.
        w_level = (io_bus.level > LAST) ? LAST : io_bus.level;
        w_first = LAST - w_level;
        w_ai    = r_a[SEG*int'(r_i) +: SEG];
        w_bj    = r_b[SEG*int'(r_j) +: SEG];
        w_prod  = w_ai * w_bj;
        w_shamt = SHW'(SEG * (int'(r_i) + int'(r_j)));
        w_pp    = (2*WIDTH)'(w_prod) << w_shamt;
        w_sum   = r_acc + w_pp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_b         <= '0;
            r_first     <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_acc       <= '0;
            r_o         <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (io_bus.in_valid && r_in_ready) begin
                        r_a        <= io_bus.a;
                        r_b        <= io_bus.b;
                        r_first    <= w_first;
                        r_i        <= w_first;
                        r_j        <= w_first;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= StMul;
                    end else begin
                        // First cycle out of reset raises in_ready here.
                        r_in_ready <= 1'b1;
                    end
                end
                StMul: begin
                    r_acc <= w_sum;
                    if (r_j == LAST) begin
                        if (r_i == LAST) begin
                            r_o         <= w_sum;
                            r_out_valid <= 1'b1;
                            r_state     <= StDone;
                        end else begin
                            r_i <= r_i + 1'b1;
                            r_j <= r_first;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                StDone: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.o         = r_o;
endmodule

// File: tb/tb_mul_seg_approx_seq.sv
// tb_mul_seg_approx_seq
// Directed bench for mul_seg_approx_seq: a 16-bit and a 12-bit instance,
// expected results queued at issue time and compared when out_valid rises.
module tb_mul_seg_approx_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mul_seg_approx_seq_if #(.WIDTH(16), .SEG(4)) if16 ();
    mul_seg_approx_seq_if #(.WIDTH(12), .SEG(4)) if12 ();

    mul_seg_approx_seq #(.WIDTH(16), .SEG(4)) dut16 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (if16.slave)
    );

    mul_seg_approx_seq #(.WIDTH(12), .SEG(4)) dut12 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (if12.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] q_exp[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: sum of kept segment products, written straight from the definition.
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input int n, input int seg, input int lvl);
        logic [63:0] sum, mask, ai, bj;
        int l;
        l    = (lvl > n - 1) ? n - 1 : lvl;
        sum  = 64'd0;
        mask = (64'd1 << seg) - 64'd1;
        for (int i = n - 1 - l; i < n; i++) begin
            for (int j = n - 1 - l; j < n; j++) begin
                ai  = (a >> (seg * i)) & mask;
                bj  = (b >> (seg * j)) & mask;
                sum = sum + ((ai * bj) << (seg * (i + j)));
            end
        end
        return sum;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic [1:0] lvl);
        if (sel) begin
            if12.in_valid = v;
            if12.a        = a[11:0];
            if12.b        = b[11:0];
            if12.level    = lvl;
        end else begin
            if16.in_valid = v;
            if16.a        = a;
            if16.b        = b;
            if16.level    = lvl;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? if12.in_ready : if16.in_ready;
    endfunction

    function automatic logic vld(input bit sel);
        return sel ? if12.out_valid : if16.out_valid;
    endfunction

    function automatic logic [63:0] res(input bit sel);
        return sel ? 64'(if12.o) : 64'(if16.o);
    endfunction

    // Issue one operation, check latency, result and the closing handshake.
    // Assumes out_ready is held high on the selected instance.
    task automatic run_op(input bit sel, input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic [1:0] lvl,
                          input logic [63:0] exp, input int lat);
        int n;
        logic [63:0] e;
        n = 0;
        while (!rdy(sel) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " in_ready"}, 64'(rdy(sel)), 64'd1);
        drive(sel, 1'b1, a, b, lvl);
        q_exp.push_back(exp);
        @(posedge clk); #1;
        // Scrambled inputs after acceptance must not leak into the result.
        drive(sel, 1'b0, ~a, ~b, ~lvl);
        check({tag, " busy"}, 64'(rdy(sel)), 64'd0);
        n = 0;
        while (!vld(sel) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        e = q_exp.pop_front();
        check({tag, " o"}, res(sel), e);
        check({tag, " done busy"}, 64'(rdy(sel)), 64'd0);
        @(posedge clk); #1;
        check({tag, " valid drop"}, 64'(vld(sel)), 64'd0);
        check({tag, " ready back"}, 64'(rdy(sel)), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra, rb;
        logic [1:0]  rl;
        logic [63:0] e;
        int          l, n;

        if16.out_ready = 1'b1;
        if12.out_ready = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'd0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 2'd0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst o16", res(1'b0), 64'd0);
        check("rst valid16", 64'(vld(1'b0)), 64'd0);
        check("rst ready16", 64'(rdy(1'b0)), 64'd0);
        check("rst o12", res(1'b1), 64'd0);
        rst = 1'b0;
        #1;
        check("ready before edge", 64'(rdy(1'b0)), 64'd0);
        @(posedge clk); #1;
        check("ready after edge", 64'(rdy(1'b0)), 64'd1);

        // Directed cases.
        run_op(1'b0, "l0_ffff", 16'hFFFF, 16'hFFFF, 2'd0, 64'hE1000000, 1);
        run_op(1'b0, "l3_ffff", 16'hFFFF, 16'hFFFF, 2'd3, 64'hFFFE0001, 16);
        run_op(1'b0, "l1_1234", 16'h1234, 16'h5678, 2'd1, 64'h060C0000, 4);
        run_op(1'b1, "w12_clamp", 16'h0FFF, 16'h0FFF, 2'd3, 64'h00FFE001, 9);

        // Random operands at exact level against a plain multiply.
        for (int k = 0; k < 4; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            e  = 64'(ra) * 64'(rb);
            run_op(1'b0, "rand_exact", ra, rb, 2'd3, e, 16);
        end

        // Random operands and levels against the segment model.
        for (int k = 0; k < 4; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rl = 2'($urandom_range(0, 3));
            l  = int'(rl);
            run_op(1'b0, "rand_lvl", ra, rb, rl, model(64'(ra), 64'(rb), 4, 4, l),
                   (l + 1) * (l + 1));
        end

        // Backpressure: result held while out_ready is low, extra request ignored.
        if16.out_ready = 1'b0;
        drive(1'b0, 1'b1, 16'h2000, 16'h3000, 2'd0);
        q_exp.push_back(64'h06000000);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'd0);
        n = 0;
        while (!vld(1'b0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp latency", 64'(n), 64'd1);
        e = q_exp.pop_front();
        for (int c = 0; c < 5; c++) begin
            check("bp o stable", res(1'b0), e);
            check("bp valid stable", 64'(vld(1'b0)), 64'd1);
            check("bp ready low", 64'(rdy(1'b0)), 64'd0);
            if (c == 1) drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 2'd3);
            else        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'd0);
            @(posedge clk); #1;
        end
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp valid drop", 64'(vld(1'b0)), 64'd0);
        check("bp ready back", 64'(rdy(1'b0)), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("bp no capture", 64'(vld(1'b0)), 64'd0);
        check("bp o held", res(1'b0), 64'h06000000);

        // Reset during MUL discards the operation and clears the result.
        drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 2'd3);
        q_exp.push_back(64'hFFFE0001);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'd0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        q_exp.delete();
        check("midrst valid", 64'(vld(1'b0)), 64'd0);
        check("midrst o", res(1'b0), 64'd0);
        check("midrst ready", 64'(rdy(1'b0)), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(1'b0, "post_rst", 16'h0003, 16'h0005, 2'd3, 64'h0000000F, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
